// File: rtl/uart_rx_flit.sv
// uart_rx_flit: oversampling 8N1 serial receiver that packs consecutive bytes
// into flits and offers them on a valid/ready port toward the router.
// Bytes arrive LSB-first; byte 0 of a flit lands in flit_data[7:0].
module uart_rx_flit #(
   parameter  int CLKS_PER_BIT   = 5208,
   parameter  int BYTES_PER_FLIT = 4,
   localparam int FLIT_W         = 8 * BYTES_PER_FLIT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rs232_rx,
   output logic [FLIT_W-1:0] flit_data,
   output logic              flit_valid,
   input  logic              flit_ready,
   output logic [7:0]        byte_data,
   output logic              byte_strobe,
   output logic              frame_err,
   output logic              overrun,
   input  logic              clear_err
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BC_W  = (BYTES_PER_FLIT > 1) ? $clog2(BYTES_PER_FLIT) : 1;

   localparam logic [CNT_W-1:0] C_HALF_M1   = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] C_FULL_M1   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BC_W-1:0]  C_LAST_BYTE = BC_W'(BYTES_PER_FLIT - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_DATA      = 3'd2;
   localparam logic [2:0] S_STOP      = 3'd3;
   localparam logic [2:0] S_WAIT_IDLE = 3'd4;

   // Synchroniser and receive FSM state
   logic              r_sync1;
   logic              r_sync2;
   logic [2:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [2:0]        r_idx;
   logic [7:0]        r_shift;

   // Byte-level outputs
   logic [7:0]        r_byte_data;
   logic              r_byte_strobe;
   logic              r_frame_err;

   // Flit assembly and output register
   logic [BC_W-1:0]   r_byte_cnt;
   logic [FLIT_W-1:0] r_flit_sr;
   logic [FLIT_W-1:0] r_flit_data;
   logic              r_flit_valid;
   logic              r_overrun;

   logic              w_rx_s;
   logic              w_stop_sample;
   logic              w_byte_good;
   logic              w_stop_bad;
   logic              w_last_byte;
   logic              w_flit_done;
   logic              w_take;
   logic [FLIT_W-1:0] w_flit_full;

   assign w_rx_s        = r_sync2;
   assign w_stop_sample = (r_state == S_STOP) && (r_cnt == C_FULL_M1);
   assign w_byte_good   = w_stop_sample && w_rx_s;
   assign w_stop_bad    = w_stop_sample && !w_rx_s;
   assign w_last_byte   = (r_byte_cnt == C_LAST_BYTE);
   assign w_flit_done   = w_byte_good && w_last_byte;
   assign w_take        = r_flit_valid && flit_ready;

   // The flit being built with the just-received byte dropped into its lane,
   // so the final byte can go straight to the output register.
   generate
      for (genvar gi = 0; gi < BYTES_PER_FLIT; gi++) begin : g_lane
         assign w_flit_full[8*gi +: 8] =
            (r_byte_cnt == BC_W'(gi)) ? r_shift : r_flit_sr[8*gi +: 8];
      end
   endgenerate

   // Two-flop synchroniser; idles high so reset never looks like a start bit
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rs232_rx;
         r_sync2 <= r_sync1;
      end
   end

   // Bit-timing FSM: centre-samples start, data and stop bits
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!w_rx_s) begin
                  r_state <= S_START;
                  r_cnt   <= '0;
               end
            end
            S_START: begin
               if (r_cnt == C_HALF_M1) begin
                  r_cnt <= '0;
                  if (!w_rx_s) begin
                     r_state <= S_DATA;
                     r_idx   <= '0;
                  end else begin
                     // Line went back high before mid-start: a glitch
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_DATA: begin
               if (r_cnt == C_FULL_M1) begin
                  r_cnt          <= '0;
                  r_shift[r_idx] <= w_rx_s;
                  if (r_idx == 3'd7) begin
                     r_state <= S_STOP;
                  end else begin
                     r_idx <= r_idx + 3'd1;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_STOP: begin
               if (r_cnt == C_FULL_M1) begin
                  r_cnt   <= '0;
                  // Leaving at mid-stop lets a back-to-back start bit be seen
                  r_state <= w_rx_s ? S_IDLE : S_WAIT_IDLE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_WAIT_IDLE: begin
               // Hold through a break so it reports only one framing error
               if (w_rx_s) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Byte result: last good byte plus one-cycle strobe / framing-error pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         r_byte_data   <= '0;
         r_byte_strobe <= 1'b0;
         r_frame_err   <= 1'b0;
      end else begin
         r_byte_strobe <= w_byte_good;
         r_frame_err   <= w_stop_bad;
         if (w_byte_good) begin
            r_byte_data <= r_shift;
         end
      end
   end

   // Flit assembly: a framing error throws away the partial flit
   always_ff @(posedge clk) begin
      if (reset) begin
         r_byte_cnt <= '0;
         r_flit_sr  <= '0;
      end else if (w_stop_bad) begin
         r_byte_cnt <= '0;
      end else if (w_byte_good) begin
         if (w_last_byte) begin
            r_byte_cnt <= '0;
         end else begin
            r_byte_cnt <= r_byte_cnt + BC_W'(1);
            r_flit_sr  <= w_flit_full;
         end
      end
   end

   // Output register: load when free or draining this cycle, else drop and flag
   always_ff @(posedge clk) begin
      if (reset) begin
         r_flit_data  <= '0;
         r_flit_valid <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         if (w_flit_done && (!r_flit_valid || w_take)) begin
            r_flit_data  <= w_flit_full;
            r_flit_valid <= 1'b1;
         end else if (w_take) begin
            r_flit_valid <= 1'b0;
         end

         // A new drop in the same cycle as clear_err keeps the flag set
         if (w_flit_done && r_flit_valid && !w_take) begin
            r_overrun <= 1'b1;
         end else if (clear_err) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign flit_data   = r_flit_data;
   assign flit_valid  = r_flit_valid;
   assign byte_data   = r_byte_data;
   assign byte_strobe = r_byte_strobe;
   assign frame_err   = r_frame_err;
   assign overrun     = r_overrun;

endmodule

// File: tb/tb_uart_rx_flit.sv
// tb_uart_rx_flit: drives serial frames (ideal and skewed) into uart_rx_flit
// and compares strobes, flits, framing errors and overrun with a byte/flit
// level reference model held in queues.
module tb_uart_rx_flit;

   localparam int CPB = 16;
   localparam int BPF = 4;

   typedef struct {
      logic [7:0] b;
      bit         last;
   } byte_ent_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rs232_rx = 1'b1;
   logic        flit_ready = 1'b1;
   logic        clear_err = 1'b0;
   logic [31:0] flit_data;
   logic        flit_valid;
   logic [7:0]  byte_data;
   logic        byte_strobe;
   logic        frame_err;
   logic        overrun;

   // Reference model state
   byte_ent_t   exp_bytes[$];
   logic [31:0] exp_flits[$];
   logic [7:0]  part[$];
   bit          slot_full = 0;
   bit          exp_overrun = 0;
   int          exp_ferr = 0;

   // Observed event counts
   int          n_strobe = 0;
   int          n_flits = 0;
   int          n_ferr = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   uart_rx_flit #(
      .CLKS_PER_BIT   (CPB),
      .BYTES_PER_FLIT (BPF)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rs232_rx    (rs232_rx),
      .flit_data   (flit_data),
      .flit_valid  (flit_valid),
      .flit_ready  (flit_ready),
      .byte_data   (byte_data),
      .byte_strobe (byte_strobe),
      .frame_err   (frame_err),
      .overrun     (overrun),
      .clear_err   (clear_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n clocks; inputs change 1 ns after the rising edge
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Model: a good byte joins the partial flit; a full flit goes to the
   // output slot unless a flit is already held there, in which case it is lost
   task automatic model_good_byte(input logic [7:0] b);
      byte_ent_t   e;
      logic [31:0] f;
      part.push_back(b);
      e.b    = b;
      e.last = (part.size() == BPF);
      exp_bytes.push_back(e);
      if (e.last) begin
         f = '0;
         for (int i = 0; i < BPF; i++) f[8*i +: 8] = part[i];
         part.delete();
         if (slot_full) begin
            exp_overrun = 1;
         end else begin
            exp_flits.push_back(f);
            if (!flit_ready) slot_full = 1;
         end
      end
   endtask

   // One 8N1 frame; skew_pct stretches/shrinks every bit. The line is left
   // at the stop-bit level so a bad stop can be extended into a break.
   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int skew_pct);
      logic [9:0] bits;
      int e0, e1;
      bits = {stop_ok, b, 1'b0};
      if (stop_ok) begin
         model_good_byte(b);
      end else begin
         exp_ferr++;
         part.delete();
      end
      for (int k = 0; k < 10; k++) begin
         e0 = (k * CPB * (100 + skew_pct) + 50) / 100;
         e1 = ((k + 1) * CPB * (100 + skew_pct) + 50) / 100;
         rs232_rx = bits[k];
         tick(e1 - e0);
      end
   endtask

   initial begin
      logic [39:0] or_data;
      logic [3:0]  or_flags;
      int          saved;
      logic [7:0]  seq[8];

      reset = 1'b1;
      tick(4);
      reset = 1'b0;
      tick(1);

      // Monitor: sampled mid-cycle, away from the rising edge
      fork
         begin : monitor
            byte_ent_t   e;
            logic        prev_valid = 1'b0;
            logic        prev_ready = 1'b0;
            logic [31:0] prev_data = '0;
            forever begin
               @(negedge clk);
               if (byte_strobe) begin
                  n_strobe++;
                  $display("byte %02h", byte_data);
                  if (exp_bytes.size() == 0) begin
                     check("unexpected_strobe", 64'd1, 64'd0);
                  end else begin
                     e = exp_bytes.pop_front();
                     check("byte_data", byte_data, e.b);
                     if (e.last) check("valid_with_last_byte", flit_valid, 1'b1);
                  end
               end
               if (frame_err) begin
                  n_ferr++;
                  $display("frame error");
               end
               if (prev_valid && !prev_ready && flit_valid) begin
                  check("flit_hold", flit_data, prev_data);
               end
               if (flit_valid && flit_ready) begin
                  n_flits++;
                  $display("flit %08h", flit_data);
                  if (exp_flits.size() == 0) begin
                     check("unexpected_flit", 64'd1, 64'd0);
                  end else begin
                     check("flit_data", flit_data, exp_flits.pop_front());
                  end
               end
               prev_valid = flit_valid;
               prev_ready = flit_ready;
               prev_data  = flit_data;
            end
         end
      join_none

      // Idle line after reset: every output stays at its reset value
      or_data  = '0;
      or_flags = '0;
      for (int i = 0; i < 1000; i++) begin
         tick(1);
         or_data  = or_data | {flit_data, byte_data};
         or_flags = or_flags | {flit_valid, byte_strobe, frame_err, overrun};
      end
      check("idle_data", or_data, 40'd0);
      check("idle_flags", or_flags, 4'd0);

      // Single byte: one strobe, no flit
      send_frame(8'hA5, 1'b1, 0);
      tick(2 * CPB);
      check("a5_strobes", n_strobe, 1);
      check("a5_no_flit", flit_valid, 1'b0);

      // Reset in mid-frame: frame and the partial flit (0xA5) are discarded
      rs232_rx = 1'b0;
      tick(CPB);
      rs232_rx = 1'b1;
      tick(CPB);
      rs232_rx = 1'b0;
      tick(3 * CPB);
      reset    = 1'b1;
      rs232_rx = 1'b1;
      tick(1);
      reset = 1'b0;
      part.delete();
      tick(12 * CPB);
      check("rst_abort_strobes", n_strobe, 1);
      check("rst_abort_ferr", n_ferr, 0);

      // One flit with the consumer ready
      send_frame(8'h11, 1'b1, 0);
      send_frame(8'h22, 1'b1, 0);
      send_frame(8'h33, 1'b1, 0);
      send_frame(8'h44, 1'b1, 0);
      tick(2 * CPB);
      check("flit1_count", n_flits, 1);
      check("flit1_valid_cleared", flit_valid, 1'b0);

      // Consumer stalled for two flits: first held, second dropped
      flit_ready = 1'b0;
      for (int i = 0; i < 8; i++) send_frame(8'(i + 1), 1'b1, 0);
      tick(2 * CPB);
      check("stall_valid", flit_valid, 1'b1);
      check("stall_data", flit_data, 32'h04030201);
      check("stall_overrun", overrun, exp_overrun);
      flit_ready = 1'b1;
      slot_full  = 0;
      tick(3);
      check("stall_drained", flit_valid, 1'b0);
      check("stall_flit_count", n_flits, 2);
      check("overrun_before_clear", overrun, 1'b1);
      clear_err = 1'b1;
      tick(1);
      clear_err   = 1'b0;
      exp_overrun = 0;
      tick(1);
      check("overrun_cleared", overrun, exp_overrun);

      // Bad stop on 2nd byte, then a 50-bit break, then a clean flit
      seq[0] = 8'($urandom);
      send_frame(seq[0], 1'b1, 0);
      send_frame(8'h3C, 1'b0, 0);
      tick(50 * CPB);
      rs232_rx = 1'b1;
      tick(2 * CPB);
      check("break_ferr", n_ferr, exp_ferr);
      for (int i = 0; i < 4; i++) send_frame(8'hAA, 1'b1, 0);
      tick(2 * CPB);
      check("break_ferr_once", n_ferr, 1);
      check("after_break_flits", n_flits, 3);

      // Short low glitch on an idle line
      saved    = n_strobe;
      rs232_rx = 1'b0;
      tick(4);
      rs232_rx = 1'b1;
      tick(3 * CPB);
      check("glitch_strobes", n_strobe, saved);
      check("glitch_ferr", n_ferr, exp_ferr);

      // Baud skew of +3 % and -3 %, frames back-to-back
      for (int i = 0; i < 4; i++) send_frame(8'h5A, 1'b1, 3);
      for (int i = 0; i < 4; i++) send_frame(8'h5A, 1'b1, -3);
      tick(2 * CPB);
      check("skew_flits", n_flits, 5);

      // Random bytes, skew, gaps and occasional bad stop bits
      for (int i = 0; i < 30; i++) begin
         logic [7:0] b;
         bit         ok;
         int         sk;
         int         gap;
         b   = 8'($urandom);
         ok  = ($urandom_range(0, 9) != 0);
         sk  = int'($urandom_range(0, 6)) - 3;
         gap = int'($urandom_range(0, 2));
         send_frame(b, ok, sk);
         if (!ok) begin
            rs232_rx = 1'b1;
            gap = gap + 1;
         end
         tick(gap * CPB);
      end

      tick(4 * CPB);
      check("bytes_left", exp_bytes.size(), 0);
      check("flits_left", exp_flits.size(), 0);
      check("ferr_total", n_ferr, exp_ferr);
      check("overrun_final", overrun, exp_overrun);
      check("valid_final", flit_valid, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_flit.md
# uart_rx_flit

Asynchronous RS-232 receiver that turns a serial line into network flits for injection into the router. It oversamples `rs232_rx` on the system clock, deserialises 8N1 bytes LSB-first, and packs `BYTES_PER_FLIT` consecutive bytes into one flit. Completed flits are presented on a valid/ready interface to the router input port. It is the receive-side counterpart of the router's `Rs232_Tx` output path and shares its baud configuration.

## Interface
- `CLKS_PER_BIT`, 5208, system clocks per bit period (50 MHz / 9600 Bd); benches override to 16; must be ≥ 4.
- `BYTES_PER_FLIT`, 4, bytes packed per flit; must be ≥ 1.
- `FLIT_W`, 8*BYTES_PER_FLIT, flit width in bits; derived, not overridden.

- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rs232_rx`  in  1  asynchronous serial line; idles high.
- `flit_data`  out  FLIT_W  assembled flit; byte 0 (first received) in bits [7:0].
- `flit_valid`  out  1  flit_data holds an unconsumed flit.
- `flit_ready`  in  1  consumer accepts; transfer happens when valid && ready.
- `byte_data`  out  8  last good byte received.
- `byte_strobe`  out  1  one-cycle pulse when byte_data updates.
- `frame_err`  out  1  one-cycle pulse on a stop bit sampled low.
- `overrun`  out  1  sticky; a completed flit was dropped.
- `clear_err`  in  1  clears `overrun`.

## Operation
- Input path: `rs232_rx` passes through a 2-flop synchroniser (both flops reset to 1); the FSM only ever uses the synchronised value `rx_s`.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE. Bit counter `cnt` has width ceil(log2(CLKS_PER_BIT)); bit index 0..7.
- IDLE: when `rx_s`==0, go to START with cnt=0.
- START: at cnt==CLKS_PER_BIT/2−1, sample `rx_s`. If 0, go to DATA with cnt=0 and index=0. If 1, treat as a glitch and return to IDLE without any output.
- DATA: at cnt==CLKS_PER_BIT−1, shift `rx_s` into bit [index] and set cnt=0. After index 7, go to STOP.
- STOP: at cnt==CLKS_PER_BIT−1, sample `rx_s`.
  - If 1: byte is good; load byte_data, pulse byte_strobe, append the byte to the flit; go to IDLE.
  - If 0: pulse frame_err; discard the byte and any partial flit (byte count←0); go to WAIT_IDLE.
- WAIT_IDLE: stay until `rx_s`==1, then go to IDLE. A break condition therefore produces exactly one frame_err.
- Flit assembly: a shift register with byte count 0..BYTES_PER_FLIT−1. Byte k lands in bits [8k+7:8k]. When the last byte of a flit arrives:
  - If the output register is empty, or is being consumed in the same cycle (valid && ready), load flit_data and set flit_valid.
  - Otherwise drop the new flit, set overrun, and leave the held flit untouched.
  - In both cases byte count←0.
- flit_valid clears on the cycle after a valid && ready handshake, unless a new flit loads in that same cycle. flit_data stays stable while valid && !ready.
- overrun: a set in the same cycle as clear_err wins (overrun stays 1).
- Reset at any time returns the FSM to IDLE and discards partial bytes and flits. No pulse is emitted for a frame cut by reset.

## Timing
- Reset values: flit_data=0, flit_valid=0, byte_data=0, byte_strobe=0, frame_err=0, overrun=0, FSM=IDLE, counters=0, synchroniser=1.
- Start edge to START entry: 3 clocks (2 synchroniser flops plus 1 IDLE decision).
- Data bit n is sampled (CLKS_PER_BIT/2 + (n+1)·CLKS_PER_BIT) clocks after START entry; the stop bit follows the same rule with n=8.
- byte_strobe and frame_err assert in the cycle after the stop-bit sample.
- For the final byte of a flit, flit_valid rises in the same cycle as byte_strobe.
- Back-to-back frames: the receiver returns to IDLE at mid-stop-bit, so a start bit immediately after a full stop bit is caught. Tolerated baud mismatch is ±4 %.
- Throughput: one flit per BYTES_PER_FLIT·10 bit times. flit_ready may be held low for up to one flit time with no loss.

## Test plan
Benches use CLKS_PER_BIT=16 and BYTES_PER_FLIT=4.
- Reset then idle line: all outputs hold their reset values for 1000 cycles; `reset` held high mid-frame for 1 cycle aborts the frame with no strobe.
- Send 0xA5 with ideal timing: byte_strobe pulses once with byte_data=0xA5; flit_valid stays 0.
- Send 0x11, 0x22, 0x33, 0x44 with flit_ready=1: flit_valid pulses 1 cycle with flit_data=0x44332211.
- Send 8 bytes 0x01..0x08 with flit_ready=0: first flit 0x04030201 is held stable, the second flit is dropped, and overrun=1; clear_err then clears overrun.
- Stop bit forced low on the 2nd byte, then line held low for 50 bit times, then bytes 0xAA×4: exactly one frame_err pulse, partial flit discarded, and the next flit is 0xAAAAAAAA.
- 4-cycle low glitch on the idle line: no byte_strobe. Baud ±3 % skew on 0x5A×4: flit_data=0x5A5A5A5A.
